// File: rtl/timer_apb_regif.sv
// timer_apb_regif
//   APB slave register block for the 8-bit timer. Decodes CPU accesses to
//   TDR (reload value), TCR (control) and TSR (sticky status). It drives the
//   counter control levels and captures overflow/underflow pulses into
//   sticky flags.
//
// Ports
//   pclk, presetn        clock (rising edge), async active-low reset
//   psel, penable,       APB request phase signals
//   pwrite, paddr, pwdata
//   prdata, pready,      APB response (registered); prdata is zero outside
//   pslverr              a read completion
//   tdr_o                reload value for the counter
//   load_o, up_dw_o,     TCR[7], TCR[5], TCR[4], TCR[1:0]
//   en_o, cks_o
//   ovf_set_i, udf_set_i one-cycle event pulses from the counter
//   ovf_o, udf_o         TSR[0], TSR[1] levels
module timer_apb_regif #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              up_dw_o,
  output logic              en_o,
  output logic [1:0]        cks_o,
  input  logic              ovf_set_i,
  input  logic              udf_set_i,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [1:0]        WAIT_TC  = 2'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] ADDR_TDR = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] ADDR_TCR = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] ADDR_TSR = ADDR_W'(8'h02);
  localparam logic [7:0]        TCR_MASK = 8'hB3;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [1:0] tsr_q, tsr_d;
  logic [7:0] prdata_q, prdata_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;

  logic       sel_tdr_s, sel_tcr_s, sel_tsr_s, addr_ok_s;
  logic       commit_wr_s;

  // Masked register read multiplexer; unmapped addresses read as zero.
  function automatic logic [7:0] read_mux(input logic s_tdr, input logic s_tcr,
                                          input logic s_tsr, input logic [7:0] tdr,
                                          input logic [7:0] tcr, input logic [1:0] tsr);
    logic [7:0] val;
    if (s_tdr) begin
      val = tdr;
    end else if (s_tcr) begin
      val = tcr & TCR_MASK;
    end else if (s_tsr) begin
      val = {6'b00_0000, tsr};
    end else begin
      val = 8'h00;
    end
    return val;
  endfunction

  assign sel_tdr_s = (paddr == ADDR_TDR);
  assign sel_tcr_s = (paddr == ADDR_TCR);
  assign sel_tsr_s = (paddr == ADDR_TSR);
  assign addr_ok_s = sel_tdr_s | sel_tcr_s | sel_tsr_s;

  // A write commits on the edge that closes the pready cycle, provided the
  // master still holds the transfer (psel dropped at that point is an abort).
  assign commit_wr_s = pready_q & psel & penable & pwrite;

  // Transfer tracking FSM and wait-state counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          state_d = ST_ACCESS;
          cnt_d   = 2'd0;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end else if (cnt_q == WAIT_TC) begin
          cnt_d   = 2'd0;
          state_d = penable ? ST_IDLE : ST_SETUP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Register file next state; a flag event wins over a same-cycle clear.
  always_comb begin
    if (commit_wr_s && sel_tdr_s) begin
      tdr_d = pwdata;
    end else begin
      tdr_d = tdr_q;
    end
    if (commit_wr_s && sel_tcr_s) begin
      tcr_d = pwdata & TCR_MASK;
    end else begin
      tcr_d = tcr_q;
    end
    if (commit_wr_s && sel_tsr_s) begin
      tsr_d = (tsr_q & pwdata[1:0]) | {udf_set_i, ovf_set_i};
    end else begin
      tsr_d = tsr_q | {udf_set_i, ovf_set_i};
    end
  end

  // Response is computed one cycle early from next-state values so the
  // registered outputs show the register contents of the pready cycle itself.
  always_comb begin
    pready_d  = (state_d == ST_ACCESS) && (cnt_d == WAIT_TC);
    pslverr_d = pready_d && !addr_ok_s;
    if (pready_d && !pwrite) begin
      prdata_d = read_mux(sel_tdr_s, sel_tcr_s, sel_tsr_s, tdr_d, tcr_d, tsr_d);
    end else begin
      prdata_d = 8'h00;
    end
  end

  // State, register and response flops.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      tdr_q     <= 8'h00;
      tcr_q     <= 8'h00;
      tsr_q     <= 2'b00;
      prdata_q  <= 8'h00;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tdr_q     <= tdr_d;
      tcr_q     <= tcr_d;
      tsr_q     <= tsr_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign tdr_o   = tdr_q;
  assign load_o  = tcr_q[7];
  assign up_dw_o = tcr_q[5];
  assign en_o    = tcr_q[4];
  assign cks_o   = tcr_q[1:0];
  assign ovf_o   = tsr_q[0];
  assign udf_o   = tsr_q[1];

endmodule

// File: tb/tb_timer_apb_regif.sv
// Bench for timer_apb_regif: two instances (WAIT_STATES 0 and 2) driven by
// directed and random APB traffic. Expected responses are queued at issue
// time and checked by an independent monitor.
module tb_timer_apb_regif;

  localparam int WS0 = 0;
  localparam int WS1 = 2;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic [1:0]      presetn, psel, penable, pwrite, pready, pslverr;
  logic [1:0]      ovf_set, udf_set, load, up_dw, en, ovf, udf;
  logic [1:0][7:0] paddr, pwdata, prdata, tdr;
  logic [1:0][1:0] cks;

  timer_apb_regif #(.WAIT_STATES(WS0), .ADDR_W(8)) dut0 (
    .pclk(pclk), .presetn(presetn[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .tdr_o(tdr[0]), .load_o(load[0]),
    .up_dw_o(up_dw[0]), .en_o(en[0]), .cks_o(cks[0]), .ovf_set_i(ovf_set[0]),
    .udf_set_i(udf_set[0]), .ovf_o(ovf[0]), .udf_o(udf[0]));

  timer_apb_regif #(.WAIT_STATES(WS1), .ADDR_W(8)) dut1 (
    .pclk(pclk), .presetn(presetn[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .tdr_o(tdr[1]), .load_o(load[1]),
    .up_dw_o(up_dw[1]), .en_o(en[1]), .cks_o(cks[1]), .ovf_set_i(ovf_set[1]),
    .udf_set_i(udf_set[1]), .ovf_o(ovf[1]), .udf_o(udf[1]));

  typedef struct packed {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  logic [1:0] prev_rdy = 2'b00;

  // Reference register contents, kept as the software-visible values.
  logic [7:0] m_tdr[2];
  logic [7:0] m_tcr[2];
  logic [1:0] m_tsr[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_read(input int d, input logic [7:0] a, input bit wr);
    exp_t e;
    e.err = (a > 8'h02);
    e.rd  = 8'h00;
    if (!wr) begin
      if (a == 8'h00)      e.rd = m_tdr[d];
      else if (a == 8'h01) e.rd = m_tcr[d];
      else if (a == 8'h02) e.rd = {6'd0, m_tsr[d]};
    end
    return e;
  endfunction

  task automatic model_reset(input int d);
    m_tdr[d] = 8'h00;
    m_tcr[d] = 8'h00;
    m_tsr[d] = 2'b00;
  endtask

  task automatic check_ctrl(input int d);
    chk($sformatf("tdr_o%0d", d), 32'(tdr[d]), 32'(m_tdr[d]));
    chk($sformatf("load_o%0d", d), 32'(load[d]), 32'(m_tcr[d][7]));
    chk($sformatf("up_dw_o%0d", d), 32'(up_dw[d]), 32'(m_tcr[d][5]));
    chk($sformatf("en_o%0d", d), 32'(en[d]), 32'(m_tcr[d][4]));
    chk($sformatf("cks_o%0d", d), 32'(cks[d]), 32'(m_tcr[d][1:0]));
    chk($sformatf("ovf_o%0d", d), 32'(ovf[d]), 32'(m_tsr[d][0]));
    chk($sformatf("udf_o%0d", d), 32'(udf[d]), 32'(m_tsr[d][1]));
  endtask

  // Monitor: every pready cycle pops one expected response.
  always @(negedge pclk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (pready[d] === 1'b1) begin
        chk($sformatf("pready_single%0d", d), 32'(prev_rdy[d]), 32'd0);
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_pready dut%0d at %0t", d, $time);
        end else begin
          if (d == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          chk($sformatf("prdata%0d", d), 32'(prdata[d]), 32'(e.rd));
          chk($sformatf("pslverr%0d", d), 32'(pslverr[d]), 32'(e.err));
        end
      end else begin
        chk($sformatf("prdata_idle%0d", d), 32'(prdata[d]), 32'd0);
      end
    end
    prev_rdy <= pready;
  end

  // Entry and exit just after a rising edge; back-to-back calls give
  // back-to-back transfers. fl pulses ovf/udf in the commit cycle.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [7:0] wd, input logic [1:0] fl);
    exp_t e;
    int   n;
    bit   got;
    e = model_read(d, a, wr);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 16) begin
      @(negedge pclk);
      n++;
      if (pready[d] === 1'b1) begin
        got = 1'b1;
        ovf_set[d] = fl[0];
        udf_set[d] = fl[1];
      end
    end
    chk($sformatf("ready_latency%0d", d), got ? 32'(n) : 32'd99,
        (d == 0) ? 32'(WS0 + 2) : 32'(WS1 + 2));
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0; ovf_set[d] = 1'b0; udf_set[d] = 1'b0;
    if (got) begin
      if (wr) begin
        if (a == 8'h00)      m_tdr[d] = wd;
        else if (a == 8'h01) m_tcr[d] = wd & 8'hB3;
        else if (a == 8'h02) m_tsr[d] = m_tsr[d] & wd[1:0];
      end
      m_tsr[d] = m_tsr[d] | fl;
    end
  endtask

  task automatic pulse_flags(input int d, input logic o, input logic u);
    ovf_set[d] = o;
    udf_set[d] = u;
    @(posedge pclk); #1;
    ovf_set[d] = 1'b0;
    udf_set[d] = 1'b0;
    m_tsr[d] = m_tsr[d] | {u, o};
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic read_all(input int d);
    xfer(d, 1'b0, 8'h00, 8'h00, 2'b00);
    xfer(d, 1'b0, 8'h01, 8'h00, 2'b00);
    xfer(d, 1'b0, 8'h02, 8'h00, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, wd;
    logic [1:0] fl;
    int d, r;
    presetn = 2'b00; psel = 2'b00; penable = 2'b00; pwrite = 2'b00;
    paddr = '0; pwdata = '0; ovf_set = 2'b00; udf_set = 2'b00;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge pclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_pready", 32'(pready[i]), 32'd0);
      chk("rst_pslverr", 32'(pslverr[i]), 32'd0);
      chk("rst_prdata", 32'(prdata[i]), 32'd0);
      check_ctrl(i);
    end
    presetn = 2'b11;
    idle(1);
    read_all(0);
    read_all(1);

    // TCR masking and control decode.
    xfer(0, 1'b1, 8'h01, 8'hFF, 2'b00);
    check_ctrl(0);
    xfer(0, 1'b0, 8'h01, 8'h00, 2'b00);
    // Reload then run sequence.
    xfer(0, 1'b1, 8'h00, 8'h5A, 2'b00);
    xfer(0, 1'b1, 8'h01, 8'h80, 2'b00);
    chk("load_between", 32'(load[0]), 32'd1);
    check_ctrl(0);
    xfer(0, 1'b1, 8'h01, 8'h13, 2'b00);
    check_ctrl(0);
    // Sticky flags and write-0-to-clear.
    pulse_flags(0, 1'b1, 1'b0);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00);
    xfer(0, 1'b1, 8'h02, 8'h02, 2'b00);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00);
    xfer(0, 1'b1, 8'h02, 8'h00, 2'b00);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00);
    xfer(0, 1'b1, 8'h02, 8'h00, 2'b10);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00);
    // Set wins over a clear of the same, already-set flag.
    pulse_flags(0, 1'b1, 1'b0);
    xfer(0, 1'b1, 8'h02, 8'h00, 2'b10);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00);
    check_ctrl(0);
    // TCR write and flag event together.
    xfer(0, 1'b1, 8'h01, 8'h21, 2'b01);
    check_ctrl(0);
    // Unmapped address.
    xfer(0, 1'b1, 8'h05, 8'hAA, 2'b00);
    xfer(0, 1'b0, 8'h05, 8'h00, 2'b00);
    read_all(0);
    check_ctrl(0);

    // Wait states, back-to-back writes.
    xfer(1, 1'b1, 8'h00, 8'hC3, 2'b00);
    xfer(1, 1'b1, 8'h01, 8'hF7, 2'b00);
    xfer(1, 1'b1, 8'h00, 8'h3C, 2'b00);
    read_all(1);
    check_ctrl(1);
    // Abort in the middle of ACCESS: no commit and no pready.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h00; pwdata[1] = 8'h77;
    idle(1);
    penable[1] = 1'b1;
    idle(1);
    psel[1] = 1'b0; penable[1] = 1'b0;
    idle(4);
    xfer(1, 1'b0, 8'h00, 8'h00, 2'b00);
    check_ctrl(1);
    // Reset in the middle of a write.
    pulse_flags(1, 1'b1, 1'b1);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h01; pwdata[1] = 8'h10;
    idle(1);
    penable[1] = 1'b1;
    idle(1);
    presetn[1] = 1'b0;
    #1;
    model_reset(1);
    check_ctrl(1);
    chk("midrst_pready", 32'(pready[1]), 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    idle(2);
    presetn[1] = 1'b1;
    idle(1);
    read_all(1);

    // Random traffic on both instances.
    for (int i = 0; i < 120; i++) begin
      d  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 7));
      if (r < 6)       a = 8'(r % 3);
      else if (r == 6) a = 8'h05;
      else             a = 8'($urandom_range(0, 255));
      wd = 8'($urandom_range(0, 255));
      fl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      xfer(d, 1'($urandom_range(0, 1)), a, wd, fl);
      if ($urandom_range(0, 2) == 0)
        pulse_flags(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 4) == 0) check_ctrl(d);
    end
    check_ctrl(0);
    check_ctrl(1);
    idle(5);
    chk("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
